// File: rtl/exe_seq_pkg.sv
// Shared encodings for the execute-unit program sequencer: instruction classes,
// field positions and FSM states.
package exe_seq_pkg;

    localparam int unsigned INSTR_BITS = 20;

    localparam logic [1:0] CLS_ALU_R = 2'b00;
    localparam logic [1:0] CLS_ALU_I = 2'b01;
    localparam logic [1:0] CLS_BR    = 2'b10;
    localparam logic [1:0] CLS_HALT  = 2'b11;

    localparam int unsigned CLS_MSB  = 19;
    localparam int unsigned CLS_LSB  = 18;
    localparam int unsigned OPER_MSB = 17;
    localparam int unsigned OPER_LSB = 15;
    localparam int unsigned RD_MSB   = 14;
    localparam int unsigned RD_LSB   = 11;
    localparam int unsigned RS0_MSB  = 10;
    localparam int unsigned RS0_LSB  = 7;
    localparam int unsigned RS1_MSB  = 6;
    localparam int unsigned RS1_LSB  = 3;
    localparam int unsigned IMM_MSB  = 5;
    localparam int unsigned IMM_LSB  = 0;
    localparam int unsigned MASK_MSB = 17;
    localparam int unsigned MASK_LSB = 14;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EXEC,
        WB
    } state_t;

endpackage

// File: rtl/exe_seq_dec.sv
// Combinational instruction decoder: splits the instruction register into fields
// and resolves the flag-conditioned branch decision.
module exe_seq_dec
    import exe_seq_pkg::*;
#(
    parameter int unsigned PC_W = 6
) (
    input  logic [INSTR_BITS-1:0] i_ir,
    input  logic [3:0]            i_flag,
    output logic [1:0]            o_cls,
    output logic [2:0]            o_oper,
    output logic [3:0]            o_rd,
    output logic [3:0]            o_rs0,
    output logic [3:0]            o_rs1,
    output logic [5:0]            o_imm,
    output logic [PC_W-1:0]       o_target,
    output logic                  o_taken
);

    logic [3:0] w_mask;

    assign o_cls    = i_ir[CLS_MSB:CLS_LSB];
    assign o_oper   = i_ir[OPER_MSB:OPER_LSB];
    assign o_rd     = i_ir[RD_MSB:RD_LSB];
    assign o_rs0    = i_ir[RS0_MSB:RS0_LSB];
    assign o_rs1    = i_ir[RS1_MSB:RS1_LSB];
    assign o_imm    = i_ir[IMM_MSB:IMM_LSB];
    assign o_target = i_ir[PC_W-1:0];
    assign w_mask   = i_ir[MASK_MSB:MASK_LSB];

    // An empty mask means an unconditional branch.
    assign o_taken = (w_mask == 4'd0) || ((w_mask & i_flag) != 4'd0);

endmodule

// File: rtl/exe_seq.sv
// Program sequencer: fetch / execute / writeback loop driving the ALU and register
// file, with flag-conditioned branches and a HALT that hands control back to the host.
module exe_seq
    import exe_seq_pkg::*;
#(
    parameter int unsigned PC_W    = 6,
    parameter int unsigned INSTR_W = 20
) (
    input  logic               i_clk,
    input  logic               i_rsn,
    input  logic               i_start,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic               i_instr_valid,
    input  logic [5:0]         i_alu_data,
    input  logic [3:0]         i_alu_flag,
    output logic [PC_W-1:0]    o_pc,
    output logic               o_fetch,
    output logic [2:0]         o_oper,
    output logic [3:0]         o_reg0,
    output logic [3:0]         o_reg1,
    output logic [5:0]         o_data,
    output logic               o_imm,
    output logic [3:0]         o_reg2,
    output logic [5:0]         o_data2,
    output logic               o_we,
    output logic [3:0]         o_flag,
    output logic               o_busy,
    output logic               o_done
);

    state_t              r_state;
    logic [PC_W-1:0]     r_pc;
    logic [INSTR_W-1:0]  r_ir;
    logic [5:0]          r_res;
    logic [3:0]          r_flag;
    logic                r_busy;

    logic [1:0]      w_cls;
    logic [2:0]      w_oper;
    logic [3:0]      w_rd;
    logic [3:0]      w_rs0;
    logic [3:0]      w_rs1;
    logic [5:0]      w_imm;
    logic [PC_W-1:0] w_target;
    logic            w_taken;
    logic            w_exec;
    logic            w_exec_alu;
    logic            w_exec_imm;

    exe_seq_dec #(
        .PC_W(PC_W)
    ) u_dec (
        .i_ir    (r_ir),
        .i_flag  (r_flag),
        .o_cls   (w_cls),
        .o_oper  (w_oper),
        .o_rd    (w_rd),
        .o_rs0   (w_rs0),
        .o_rs1   (w_rs1),
        .o_imm   (w_imm),
        .o_target(w_target),
        .o_taken (w_taken)
    );

    always_ff @(posedge i_clk or negedge i_rsn) begin
        if (!i_rsn) begin
            r_state <= IDLE;
            r_pc    <= '0;
            r_ir    <= '0;
            r_res   <= '0;
            r_flag  <= '0;
            r_busy  <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state <= FETCH;
                        r_pc    <= '0;
                        r_flag  <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                FETCH: begin
                    if (i_instr_valid) begin
                        r_ir    <= i_instr;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    unique case (w_cls)
                        CLS_ALU_R, CLS_ALU_I: begin
                            r_res   <= i_alu_data;
                            r_flag  <= i_alu_flag;
                            r_state <= WB;
                        end
                        CLS_BR: begin
                            r_pc    <= w_taken ? w_target : r_pc + PC_W'(1);
                            r_state <= FETCH;
                        end
                        CLS_HALT: begin
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
                        default: r_state <= IDLE;
                    endcase
                end
                WB: begin
                    r_pc    <= r_pc + PC_W'(1);
                    r_state <= FETCH;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Operand and writeback ports are gated so they read 0 outside their own cycle.
    assign w_exec     = (r_state == EXEC);
    assign w_exec_alu = w_exec && ((w_cls == CLS_ALU_R) || (w_cls == CLS_ALU_I));
    assign w_exec_imm = w_exec && (w_cls == CLS_ALU_I);

    assign o_pc    = r_pc;
    assign o_fetch = (r_state == FETCH);
    assign o_oper  = w_exec_alu ? w_oper : 3'd0;
    assign o_reg0  = w_exec_alu ? w_rs0 : 4'd0;
    assign o_reg1  = w_exec_alu ? w_rs1 : 4'd0;
    assign o_imm   = w_exec_imm;
    assign o_data  = w_exec_imm ? w_imm : 6'd0;
    assign o_we    = (r_state == WB);
    assign o_reg2  = o_we ? w_rd : 4'd0;
    assign o_data2 = o_we ? r_res : 6'd0;
    assign o_flag  = r_flag;
    assign o_busy  = r_busy;
    assign o_done  = w_exec && (w_cls == CLS_HALT);

endmodule

// File: tb/tb_exe_seq.sv
// Bench for exe_seq: an instruction-level interpreter expands each program into an
// expected per-cycle output trace that is compared against the DUT every cycle.
module tb_exe_seq;

    logic        i_clk = 1'b0;
    logic        i_rsn = 1'b1;
    logic        i_start = 1'b0;
    logic [19:0] i_instr = '0;
    logic        i_instr_valid = 1'b0;
    logic [5:0]  i_alu_data;
    logic [3:0]  i_alu_flag;
    logic [5:0]  o_pc;
    logic        o_fetch;
    logic [2:0]  o_oper;
    logic [3:0]  o_reg0;
    logic [3:0]  o_reg1;
    logic [5:0]  o_data;
    logic        o_imm;
    logic [3:0]  o_reg2;
    logic [5:0]  o_data2;
    logic        o_we;
    logic [3:0]  o_flag;
    logic        o_busy;
    logic        o_done;

    exe_seq #(
        .PC_W   (6),
        .INSTR_W(20)
    ) dut (
        .i_clk        (i_clk),
        .i_rsn        (i_rsn),
        .i_start      (i_start),
        .i_instr      (i_instr),
        .i_instr_valid(i_instr_valid),
        .i_alu_data   (i_alu_data),
        .i_alu_flag   (i_alu_flag),
        .o_pc         (o_pc),
        .o_fetch      (o_fetch),
        .o_oper       (o_oper),
        .o_reg0       (o_reg0),
        .o_reg1       (o_reg1),
        .o_data       (o_data),
        .o_imm        (o_imm),
        .o_reg2       (o_reg2),
        .o_data2      (o_data2),
        .o_we         (o_we),
        .o_flag       (o_flag),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    initial forever #5 i_clk = ~i_clk;

    typedef struct packed {
        logic       fetch;
        logic [5:0] pc;
        logic [2:0] oper;
        logic [3:0] reg0;
        logic [3:0] reg1;
        logic [5:0] data;
        logic       imm;
        logic [3:0] reg2;
        logic [5:0] data2;
        logic       we;
        logic [3:0] flag;
        logic       busy;
        logic       done;
    } vec_t;

    logic [19:0] prog [64];
    vec_t        exp_q[$];
    vec_t        last_trace[$];
    vec_t        idle_exp = '0;
    bit          cmp_en = 1'b0;
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          launch_cyc = 0;
    int          fetch_wait = 0;

    // Stand-in ALU: result = operand sum plus opcode, flags = low nibble of the result.
    function automatic logic [9:0] alu_fn(input logic [2:0] oper, input logic [3:0] a,
                                          input logic [3:0] b, input logic [5:0] imm,
                                          input logic is_imm);
        logic [5:0] s;
        s = is_imm ? (imm + 6'(oper)) : (6'(a) + 6'(b) + 6'(oper));
        return {s[3:0], s};
    endfunction

    logic [9:0] alu_out;
    always_comb begin
        alu_out    = alu_fn(o_oper, o_reg0, o_reg1, o_data, o_imm);
        i_alu_data = alu_out[5:0];
        i_alu_flag = alu_out[9:6];
    end

    function automatic logic [19:0] enc_alu_i(input logic [2:0] op, input logic [3:0] rd,
                                              input logic [3:0] rs0, input logic [5:0] imm);
        return {2'b01, op, rd, rs0, 1'b0, imm};
    endfunction

    function automatic logic [19:0] enc_alu_r(input logic [2:0] op, input logic [3:0] rd,
                                              input logic [3:0] rs0, input logic [3:0] rs1);
        return {2'b00, op, rd, rs0, rs1, 3'b000};
    endfunction

    function automatic logic [19:0] enc_br(input logic [3:0] mask, input logic [5:0] tgt);
        return {2'b10, mask, 8'd0, tgt};
    endfunction

    localparam logic [19:0] HALT_W = {2'b11, 18'd0};

    function automatic vec_t dut_vec();
        vec_t v;
        v.fetch = o_fetch;
        v.pc    = o_pc;
        v.oper  = o_oper;
        v.reg0  = o_reg0;
        v.reg1  = o_reg1;
        v.data  = o_data;
        v.imm   = o_imm;
        v.reg2  = o_reg2;
        v.data2 = o_data2;
        v.we    = o_we;
        v.flag  = o_flag;
        v.busy  = o_busy;
        v.done  = o_done;
        return v;
    endfunction

    task automatic check_vec(input string name, input vec_t act, input vec_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: actual %h required %h", name, cyc, act, exp);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    // Interpret the program from pc 0 and expand each instruction into its cycles.
    task automatic build_trace(input int fw);
        logic [5:0]  pc;
        logic [3:0]  flag;
        logic [3:0]  mask;
        logic [19:0] ins;
        logic [9:0]  r;
        vec_t        v;
        pc   = '0;
        flag = '0;
        for (int n = 0; n < 100; n++) begin
            ins = prog[pc];
            v = '0;
            v.busy = 1'b1;
            v.pc = pc;
            v.flag = flag;
            v.fetch = 1'b1;
            for (int k = 0; k <= fw; k++) exp_q.push_back(v);
            v.fetch = 1'b0;
            if (ins[19] == 1'b0) begin
                v.oper = ins[17:15];
                v.reg0 = ins[10:7];
                v.reg1 = ins[6:3];
                v.imm  = ins[18];
                v.data = ins[18] ? ins[5:0] : 6'd0;
                exp_q.push_back(v);
                r = alu_fn(v.oper, v.reg0, v.reg1, v.data, v.imm);
                flag = r[9:6];
                v = '0;
                v.busy  = 1'b1;
                v.pc    = pc;
                v.flag  = flag;
                v.we    = 1'b1;
                v.reg2  = ins[14:11];
                v.data2 = r[5:0];
                exp_q.push_back(v);
                pc = pc + 6'd1;
            end else if (ins[18] == 1'b0) begin
                exp_q.push_back(v);
                mask = ins[17:14];
                pc = (mask == 4'd0 || (mask & flag) != 4'd0) ? ins[5:0] : pc + 6'd1;
            end else begin
                v.done = 1'b1;
                exp_q.push_back(v);
                break;
            end
        end
        idle_exp      = '0;
        idle_exp.pc   = pc;
        idle_exp.flag = flag;
    endtask

    task automatic clear_prog();
        for (int a = 0; a < 64; a++) prog[a] = HALT_W;
    endtask

    task automatic launch(input int fw);
        @(posedge i_clk);
        #1;
        launch_cyc = cyc;
        fetch_wait = fw;
        exp_q.push_back(idle_exp);
        i_start = 1'b1;
        build_trace(fw);
        last_trace = exp_q;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic pulse_at(input int j);
        while (cyc < launch_cyc + j) begin
            @(posedge i_clk);
            #1;
        end
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic wait_drain();
        int k;
        for (k = 0; k < 400; k++) begin
            if (exp_q.size() == 0) break;
            @(posedge i_clk);
        end
        if (k == 400) check_val("drain_timeout", exp_q.size(), 0);
        repeat (3) @(posedge i_clk);
    endtask

    always @(posedge i_clk) cyc <= cyc + 1;

    always @(negedge i_clk) begin
        if (cmp_en) begin
            if (exp_q.size() > 0) check_vec("cycle", dut_vec(), exp_q.pop_front());
            else check_vec("idle", dut_vec(), idle_exp);
        end
    end

    // Fetch responder: holds valid off for fetch_wait cycles, then serves prog[o_pc].
    initial begin
        int fcnt;
        fcnt = 0;
        forever begin
            @(posedge i_clk);
            #1;
            if (o_fetch) begin
                if (fcnt >= fetch_wait) begin
                    i_instr_valid = 1'b1;
                    i_instr = prog[o_pc];
                end else begin
                    i_instr_valid = 1'b0;
                    i_instr = 20'($urandom);
                end
                fcnt++;
            end else begin
                fcnt = 0;
                i_instr_valid = 1'b0;
                i_instr = '0;
            end
        end
    end

    initial begin
        int wi;
        vec_t zero_v;
        zero_v = '0;
        clear_prog();

        #1 i_rsn = 1'b0;
        #1 check_vec("reset_init", dut_vec(), zero_v);
        #20 i_rsn = 1'b1;
        idle_exp = '0;
        cmp_en = 1'b1;

        // ADD imm 5 into r3, then HALT, with no fetch wait.
        clear_prog();
        prog[0] = enc_alu_i(3'd0, 4'd3, 4'd0, 6'd5);
        prog[1] = HALT_W;
        launch(0);
        check_val("p2_exec_imm", int'(last_trace[2].imm), 1);
        check_val("p2_exec_data", int'(last_trace[2].data), 5);
        check_val("p2_wb_reg2", int'(last_trace[3].reg2), 3);
        check_val("p2_wb_data2", int'(last_trace[3].data2), 5);
        check_val("p2_done_slot", int'(last_trace[5].done), 1);
        check_val("p2_len", last_trace.size(), 6);
        wait_drain();

        // Asynchronous reset while the writeback strobe is up.
        launch(0);
        for (wi = 0; wi < 50; wi++) begin
            @(negedge i_clk);
            if (o_we) break;
        end
        check_val("we_seen", wi < 50 ? 1 : 0, 1);
        #1;
        cmp_en = 1'b0;
        exp_q.delete();
        i_rsn = 1'b0;
        #1 check_vec("reset_mid_wb", dut_vec(), zero_v);
        @(posedge i_clk);
        #2 i_rsn = 1'b1;
        idle_exp = '0;
        cmp_en = 1'b1;

        // Same program after reset, with valid withheld 4 cycles per fetch.
        launch(4);
        check_val("p3_fetch_run", int'(last_trace[5].fetch), 1);
        check_val("p3_exec_after_wait", int'(last_trace[6].imm), 1);
        wait_drain();

        // Flag-conditioned branches; start pulses while busy and on the done cycle.
        clear_prog();
        prog[0] = enc_alu_i(3'd0, 4'd1, 4'd0, 6'd2);
        prog[1] = enc_br(4'b0010, 6'd9);
        prog[9] = enc_br(4'b0100, 6'd20);
        prog[10] = HALT_W;
        launch(0);
        check_val("p4_flag", int'(last_trace[3].flag), 2);
        check_val("p4_taken_pc", int'(last_trace[6].pc), 9);
        check_val("p4_fall_pc", int'(last_trace[8].pc), 10);
        check_val("p4_done_slot", int'(last_trace[9].done), 1);
        pulse_at(3);
        pulse_at(last_trace.size() - 1);
        wait_drain();
        check_val("p4_halt_pc_held", int'(idle_exp.pc), 10);

        // Later pulse restarts; flags clear on start, and pc wraps 63 -> 0.
        clear_prog();
        prog[0] = enc_br(4'b0010, 6'd20);
        prog[1] = enc_br(4'b0000, 6'd63);
        prog[63] = enc_alu_r(3'd0, 4'd2, 4'd3, 4'd7);
        prog[20] = HALT_W;
        launch(1);
        check_val("p5_first_fetch_pc", int'(last_trace[1].pc), 0);
        for (int i = 0; i + 2 < last_trace.size(); i++) begin
            if (last_trace[i].we) begin
                check_val("p5_wb_pc", int'(last_trace[i].pc), 63);
                check_val("p5_wb_data2", int'(last_trace[i].data2), 10);
                check_val("p5_wrap_pc", int'(last_trace[i + 1].pc), 0);
                break;
            end
        end
        wait_drain();
        check_val("p5_end_pc", int'(idle_exp.pc), 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
